// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decides freeze/bubble/flush for each stage from
// register dependencies, taken branches and data-memory wait, and counts stall cycles.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             two_src,
  input  logic [4:0]       exe_dest,
  input  logic [4:0]       mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_r_en,
  input  logic             fwd_en,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             id_ex_bubble,
  output logic             if_flush,
  output logic             id_ex_freeze,
  output logic             ex_mem_freeze,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;

  logic hit_exe1, hit_exe2, hit_mem1, hit_mem2;
  logic data_hz;
  logic mem_stall;
  logic err;
  logic hold;

  // Register 0 is hard-wired zero, so a dependency on it is never real.
  assign hit_exe1 = (src1 != 5'd0) && (src1 == exe_dest) && exe_wb_en;
  assign hit_mem1 = (src1 != 5'd0) && (src1 == mem_dest) && mem_wb_en;
  assign hit_exe2 = two_src && (src2 != 5'd0) && (src2 == exe_dest) && exe_wb_en;
  assign hit_mem2 = two_src && (src2 != 5'd0) && (src2 == mem_dest) && mem_wb_en;

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign data_hz = fwd_en ? ((hit_exe1 || hit_exe2) && exe_mem_r_en)
                          : (hit_exe1 || hit_exe2 || hit_mem1 || hit_mem2);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mem_stall = 1'b0;
    unique case (state)
      RUN:      mem_stall = mem_req && !mem_ready;
      MEM_WAIT: mem_stall = !mem_ready;
      default:  mem_stall = 1'b0;
    endcase
  end

  assign err  = (state == ERROR);
  assign hold = err || mem_stall;

  // A memory stall freezes the whole front of the pipe and drains MEM-WB;
  // a data hazard only holds fetch/decode and injects a bubble into EXE.
  assign pc_freeze     = hold || data_hz;
  assign if_id_freeze  = hold || data_hz;
  assign id_ex_bubble  = !hold && data_hz;
  assign if_flush      = !hold && !data_hz && br_taken;
  assign id_ex_freeze  = hold;
  assign ex_mem_freeze = hold;
  assign mem_wb_bubble = hold;
  assign mem_err       = err;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          wait_cnt <= '0;
          if (mem_req && !mem_ready) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERROR:   state <= ERROR;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (pc_freeze && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum consecutive memory-wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-005 src1, src2  input  5 each  ID-stage source register numbers.
REQ-006 two_src  input  1  ID instruction reads src2 (non-immediate, or store/BNE).
REQ-007 exe_dest, mem_dest  input  5 each  destination registers in EXE and MEM stages.
REQ-008 exe_wb_en, mem_wb_en  input  1 each  EXE/MEM instruction writes back.
REQ-009 exe_mem_r_en  input  1  EXE instruction is a load.
REQ-010 fwd_en  input  1  forwarding unit enabled.
REQ-011 br_taken  input  1  branch resolved taken in ID.
REQ-012 mem_req  input  1  MEM stage holds a load or store.
REQ-013 mem_ready  input  1  data memory access complete this cycle.
REQ-014 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-015 pc_freeze, if_id_freeze  output  1 each  hold PC / IF-ID register.
REQ-016 id_ex_bubble  output  1  load NOP into ID-EX register.
REQ-017 if_flush  output  1  clear IF-ID register (squash fetched instruction).
REQ-018 id_ex_freeze, ex_mem_freeze  output  1 each  hold ID-EX / EX-MEM registers.
REQ-019 mem_wb_bubble  output  1  load NOP into MEM-WB register.
REQ-020 mem_err  output  1  sticky memory timeout flag.
REQ-021 stall_cnt  output  CNT_W  count of stall cycles.

Function
REQ-022 FSM states SHALL be RUN, MEM_WAIT, ERROR; reset state RUN.
REQ-023 Register 0 SHALL never cause a hazard; src2 SHALL be compared only when two_src=1.
REQ-024 fwd_en=0: data_hz SHALL be 1 when a compared source equals exe_dest with exe_wb_en=1, or equals mem_dest with mem_wb_en=1.
REQ-025 fwd_en=1: data_hz SHALL be 1 only when a compared source equals exe_dest with exe_wb_en=1 and exe_mem_r_en=1 (load-use).
REQ-026 mem_stall SHALL be 1 in RUN when mem_req=1 and mem_ready=0, and in MEM_WAIT when mem_ready=0; 0 otherwise in RUN/MEM_WAIT.
REQ-027 Priority SHALL be ERROR > mem_stall > data_hz > br_taken.
REQ-028 mem_stall or ERROR: pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze, mem_wb_bubble SHALL be 1; id_ex_bubble and if_flush SHALL be 0.
REQ-029 data_hz without mem_stall: pc_freeze, if_id_freeze, id_ex_bubble SHALL be 1; all others 0; br_taken ignored (re-evaluated next cycle).
REQ-030 br_taken alone: if_flush SHALL be 1; all others 0.
REQ-031 Control outputs SHALL be combinational from state and current inputs (zero-cycle latency).
REQ-032 RUN -> MEM_WAIT when mem_req=1 and mem_ready=0; MEM_WAIT -> RUN on mem_ready=1, freezes dropping in that same cycle.
REQ-033 A wait counter SHALL count MEM_WAIT cycles; cleared on entry to RUN; on reaching TIMEOUT with mem_ready=0, MEM_WAIT -> ERROR.
REQ-034 ERROR SHALL be absorbing until reset; mem_err=1 while in ERROR.
REQ-035 stall_cnt SHALL increment each cycle in which pc_freeze=1, saturate at all-ones, and clear when cnt_clr=1 (clear wins over increment).

Reset
REQ-036 rst=0 SHALL immediately force state RUN, wait counter 0, stall_cnt 0, mem_err 0, regardless of clk.
REQ-037 Reset mid-MEM_WAIT or in ERROR SHALL abort the wait; after release, outputs follow REQ-024..030 from RUN.

Verification
REQ-038 fwd_en=0, src1=3, exe_dest=3, exe_wb_en=1 -> pc_freeze=if_id_freeze=id_ex_bubble=1; with src1=0 and exe_dest=0 -> all 0.
REQ-039 fwd_en=1, src2=5, two_src=1, exe_dest=5, exe_wb_en=1, exe_mem_r_en=0 -> no stall; exe_mem_r_en=1 -> one bubble cycle, stall_cnt +1.
REQ-040 br_taken=1 with load-use hazard -> if_flush=0, bubble=1; hazard cleared next cycle with br_taken=1 -> if_flush=1.
REQ-041 mem_req=1, mem_ready=0 for 3 cycles then 1 -> all freezes high 3 cycles, low on ready cycle, state RUN, stall_cnt=3.
REQ-042 TIMEOUT=4, mem_ready held 0 -> ERROR after 4 wait cycles, mem_err=1 sticky; rst=0 asynchronously -> mem_err=0, stall_cnt=0.
REQ-043 stall_cnt with CNT_W=4 held stalled 20 cycles -> saturates at 15; cnt_clr=1 during stall -> 0.
